adc_acq_scheduler: RTL and testbench
====================================

ADC_ACQ_SCHEDULER -- requirements
Module: adc_acq_scheduler

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles allowed in WAIT_ACK.
REQ-002 SHALL have parameter CONV_TIMEOUT, default 65535: maximum cycles allowed in WAIT_DATA.
REQ-003 SHALL have port clk_i, input, 1: single clock, 27 MHz; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1: one-cycle conversion trigger from the PWM modulator.
REQ-006 SHALL have ports adc1_ready_i and adc2_ready_i, input, 1 each: ADC driver data-ready; low while busy.
REQ-007 SHALL have ports adc1_data_i and adc2_data_i, input, 16 each: ADC driver result, two's complement.
REQ-008 SHALL have ports adc1_enable_o and adc2_enable_o, output, 1 each: ADC driver enables.
REQ-009 SHALL have ports vfc_o and vout_o, output, 12 each: clamped results, ADC1 (flying cap) and ADC2 (Vout).
REQ-010 SHALL have port eoc_o, output, 1: one-cycle end-of-conversion pulse.
REQ-011 SHALL have port busy_o, output, 1: high whenever state is not IDLE.
REQ-012 SHALL have port err_clr_i, input, 1: clears the sticky error flags.
REQ-013 SHALL have ports timeout_o and overrun_o, output, 1 each: sticky error flags.
REQ-014 SHALL have port sample_cnt_o, output, 16: count of completed conversions, saturating.

Function
REQ-015 SHALL implement exactly five states: IDLE, WAIT_ACK, WAIT_DATA, DONE, ABORT.
REQ-016 IDLE: enables low; on start_i, SHALL set both enables, clear done flags, clear the timer, and go to WAIT_ACK; enables are high on the next cycle.
REQ-017 WAIT_ACK: on both ready inputs low, SHALL clear the timer and go to WAIT_DATA; otherwise, when timer == ACK_TIMEOUT-1, SHALL go to ABORT.
REQ-018 WAIT_DATA, per channel: on readyN high with doneN clear, SHALL latch the result, drop enableN and set doneN; both channels may capture in the same cycle.
REQ-019 Clamp rule: if data[15]=1, the output SHALL be 12'd0; otherwise the output SHALL be data[14:3].
REQ-020 WAIT_DATA: when both registered done flags are set, SHALL go to DONE; this takes priority over timeout.
REQ-021 WAIT_DATA: otherwise, when timer == CONV_TIMEOUT-1, SHALL go to ABORT; a capture in that same cycle still updates its output.
REQ-022 DONE: SHALL assert eoc_o for exactly this one cycle, increment sample_cnt_o (saturating at 16'hFFFF), and go to IDLE.
REQ-023 vfc_o and vout_o SHALL be stable no later than the cycle eoc_o is high.
REQ-024 ABORT: SHALL drive both enables low, set timeout_o, emit no eoc_o, leave sample_cnt_o unchanged, and go to IDLE next cycle.
REQ-025 ABORT: channels not captured SHALL keep their previous output values.
REQ-026 start_i in any state other than IDLE SHALL be ignored and SHALL set overrun_o.
REQ-027 The timer SHALL be 16 bits and increment every cycle in WAIT_ACK and WAIT_DATA.
REQ-028 err_clr_i SHALL clear timeout_o and overrun_o; if a set event occurs in the same cycle, the set wins.

Reset
REQ-029 On rst_i high at a clock edge: state IDLE, enables 0, vfc_o/vout_o 0, eoc_o 0, timeout_o/overrun_o 0, sample_cnt_o 0, timer 0, done flags 0.
REQ-030 Reset mid-conversion SHALL abandon the conversion with no eoc_o, and enables SHALL be low on the cycle after the reset edge.

Verification
REQ-031 Normal: start_i; ready both drop after 3 cycles; adc1 returns 16'h3000 after 40 cycles, adc2 returns 16'h1008 after 55 cycles -> vfc_o=12'h600, vout_o=12'h201, one eoc_o pulse, sample_cnt_o=1.
REQ-032 Negative clamp plus simultaneous capture: both ready rise on the same cycle, data 16'h8123 and 16'h7FFF -> vfc_o=0, vout_o=12'hFFF, eoc_o exactly one cycle later.
REQ-033 Ack timeout: ready held high after start_i -> ABORT after 255 cycles in WAIT_ACK, timeout_o=1, no eoc_o, outputs unchanged; err_clr_i -> timeout_o=0.
REQ-034 Conversion timeout: adc2_ready_i never rises -> vfc_o updated, vout_o unchanged, timeout_o=1, enables low, sample_cnt_o unchanged.
REQ-035 Overrun: second start_i during WAIT_DATA -> overrun_o=1, exactly one eoc_o; err_clr_i and start_i in the same IDLE cycle -> overrun_o=0, new conversion starts.
REQ-036 Reset mid-WAIT_DATA and saturation: rst_i high -> all outputs 0 next cycle, no eoc_o; sample_cnt_o forced to 16'hFFFE then two conversions -> 16'hFFFF held.

Source files
------------

// File: rtl/adc_acq_scheduler.sv
// -----------------------------------------------------------------------------
// adc_acq_scheduler
// Sequences one dual-channel ADC acquisition per start trigger from the PWM
// modulator. It waits for both ADC drivers to acknowledge (ready low), captures
// each channel's result when its ready rises, and clamps the 16-bit two's
// complement result to an unsigned 12-bit value. It then reports completion
// with a one-cycle eoc_o pulse. Hangs in either wait phase are bounded by
// timers that abort the conversion and raise a sticky timeout flag.
//
// Ports
//   clk_i          : 27 MHz system clock, rising edge
//   rst_i          : synchronous, active-high reset
//   start_i        : one-cycle conversion trigger
//   adc1/2_ready_i : ADC driver data-ready (low while busy)
//   adc1/2_data_i  : ADC driver result, two's complement
//   adc1/2_enable_o: ADC driver enables
//   vfc_o          : clamped ADC1 result (flying capacitor voltage)
//   vout_o         : clamped ADC2 result (output voltage)
//   eoc_o          : one-cycle end-of-conversion pulse
//   busy_o         : high whenever the scheduler is not idle
//   err_clr_i      : clears the sticky error flags
//   timeout_o      : sticky, set when a conversion is aborted on timeout
//   overrun_o      : sticky, set by start_i while not idle
//   sample_cnt_o   : completed conversions, saturating
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | enables low, waiting for start_i
// WAIT_ACK  | enables high, waiting for both ready inputs to drop
// WAIT_DATA | capturing each channel as its ready rises
// DONE      | eoc_o high for this single cycle
// ABORT     | timeout hit; enables low, timeout flag set, no eoc_o
// -----------------------------------------------------------------------------
module adc_acq_scheduler #(
    parameter int ACK_TIMEOUT  = 255,
    parameter int CONV_TIMEOUT = 65535
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        adc1_ready_i,
    input  logic        adc2_ready_i,
    input  logic [15:0] adc1_data_i,
    input  logic [15:0] adc2_data_i,
    output logic        adc1_enable_o,
    output logic        adc2_enable_o,
    output logic [11:0] vfc_o,
    output logic [11:0] vout_o,
    output logic        eoc_o,
    output logic        busy_o,
    input  logic        err_clr_i,
    output logic        timeout_o,
    output logic        overrun_o,
    output logic [15:0] sample_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_WAIT_DATA,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] CONV_LAST = 16'(CONV_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        done1_q, done1_d;
    logic        done2_q, done2_d;
    logic        en1_q, en1_d;
    logic        en2_q, en2_d;
    logic [11:0] vfc_q, vfc_d;
    logic [11:0] vout_q, vout_d;
    logic        eoc_q, eoc_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic        timeout_set;
    logic        overrun_set;

    // The three LSBs sit below the 12-bit output resolution and are dropped.
    logic unused_lsbs;
    assign unused_lsbs = ^{adc1_data_i[2:0], adc2_data_i[2:0]};

    // Negative readings clamp to zero; positive readings keep bits [14:3].
    function automatic logic [11:0] clamp12(input logic [15:0] data);
        return data[15] ? 12'd0 : data[14:3];
    endfunction

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        done1_d      = done1_q;
        done2_d      = done2_q;
        en1_d        = en1_q;
        en2_d        = en2_q;
        vfc_d        = vfc_q;
        vout_d       = vout_q;
        eoc_d        = 1'b0;
        sample_cnt_d = sample_cnt_q;
        timeout_set  = 1'b0;
        overrun_set  = start_i && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                en1_d = 1'b0;
                en2_d = 1'b0;
                if (start_i) begin
                    en1_d   = 1'b1;
                    en2_d   = 1'b1;
                    done1_d = 1'b0;
                    done2_d = 1'b0;
                    timer_d = 16'd0;
                    state_d = S_WAIT_ACK;
                end
            end

            S_WAIT_ACK: begin
                timer_d = timer_q + 16'd1;
                if (!adc1_ready_i && !adc2_ready_i) begin
                    timer_d = 16'd0;
                    state_d = S_WAIT_DATA;
                end else if (timer_q == ACK_LAST) begin
                    en1_d       = 1'b0;
                    en2_d       = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = S_ABORT;
                end
            end

            S_WAIT_DATA: begin
                timer_d = timer_q + 16'd1;
                // Captures run independently of the exit decision so a result
                // arriving on the timeout cycle still lands in its output.
                if (adc1_ready_i && !done1_q) begin
                    vfc_d   = clamp12(adc1_data_i);
                    en1_d   = 1'b0;
                    done1_d = 1'b1;
                end
                if (adc2_ready_i && !done2_q) begin
                    vout_d  = clamp12(adc2_data_i);
                    en2_d   = 1'b0;
                    done2_d = 1'b1;
                end
                // Completion is judged on the registered flags, so it wins
                // over a timeout that expires in the same cycle.
                if (done1_q && done2_q) begin
                    eoc_d        = 1'b1;
                    sample_cnt_d = (sample_cnt_q == 16'hFFFF) ? sample_cnt_q
                                                              : sample_cnt_q + 16'd1;
                    state_d      = S_DONE;
                end else if (timer_q == CONV_LAST) begin
                    en1_d       = 1'b0;
                    en2_d       = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = S_ABORT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ABORT: begin
                en1_d   = 1'b0;
                en2_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                en1_d   = 1'b0;
                en2_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A set event in the same cycle as a clear leaves the flag set.
        timeout_d = (timeout_q && !err_clr_i) || timeout_set;
        overrun_d = (overrun_q && !err_clr_i) || overrun_set;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            timer_q      <= 16'd0;
            done1_q      <= 1'b0;
            done2_q      <= 1'b0;
            en1_q        <= 1'b0;
            en2_q        <= 1'b0;
            vfc_q        <= 12'd0;
            vout_q       <= 12'd0;
            eoc_q        <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
            sample_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            done1_q      <= done1_d;
            done2_q      <= done2_d;
            en1_q        <= en1_d;
            en2_q        <= en2_d;
            vfc_q        <= vfc_d;
            vout_q       <= vout_d;
            eoc_q        <= eoc_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign adc1_enable_o = en1_q;
    assign adc2_enable_o = en2_q;
    assign vfc_o         = vfc_q;
    assign vout_o        = vout_q;
    assign eoc_o         = eoc_q;
    assign busy_o        = (state_q != S_IDLE);
    assign timeout_o     = timeout_q;
    assign overrun_o     = overrun_q;
    assign sample_cnt_o  = sample_cnt_q;

endmodule

// File: tb/tb_adc_acq_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_acq_scheduler
// Directed bench for adc_acq_scheduler. Inputs change 1 time unit after the
// rising edge; outputs are checked at the same point, so each check sees the
// state produced by the edge just passed. CONV_TIMEOUT is shortened to 300 so
// the conversion-timeout case stays short.
// -----------------------------------------------------------------------------
module tb_adc_acq_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        adc1_ready_i = 1'b1;
    logic        adc2_ready_i = 1'b1;
    logic [15:0] adc1_data_i = 16'd0;
    logic [15:0] adc2_data_i = 16'd0;
    logic        err_clr_i = 1'b0;
    logic        adc1_enable_o;
    logic        adc2_enable_o;
    logic [11:0] vfc_o;
    logic [11:0] vout_o;
    logic        eoc_o;
    logic        busy_o;
    logic        timeout_o;
    logic        overrun_o;
    logic [15:0] sample_cnt_o;

    int errors = 0;
    int checks = 0;
    int eoc_seen = 0;

    always #5 clk_i = ~clk_i;

    adc_acq_scheduler #(
        .ACK_TIMEOUT (255),
        .CONV_TIMEOUT(300)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .adc1_ready_i (adc1_ready_i),
        .adc2_ready_i (adc2_ready_i),
        .adc1_data_i  (adc1_data_i),
        .adc2_data_i  (adc2_data_i),
        .adc1_enable_o(adc1_enable_o),
        .adc2_enable_o(adc2_enable_o),
        .vfc_o        (vfc_o),
        .vout_o       (vout_o),
        .eoc_o        (eoc_o),
        .busy_o       (busy_o),
        .err_clr_i    (err_clr_i),
        .timeout_o    (timeout_o),
        .overrun_o    (overrun_o),
        .sample_cnt_o (sample_cnt_o)
    );

    // Every cycle eoc_o is high adds one; a pulse longer than a cycle shows up.
    always @(negedge clk_i) begin
        if (eoc_o) eoc_seen++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fastest legal conversion; eoc_o must appear within a small cycle budget.
    task automatic run_conv(input logic [15:0] d1, input logic [15:0] d2);
        logic got;
        got = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        adc1_ready_i = 1'b0;
        adc2_ready_i = 1'b0;
        tick();
        adc1_data_i = d1;
        adc2_data_i = d2;
        adc1_ready_i = 1'b1;
        adc2_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (eoc_o) begin
                got = 1'b1;
                break;
            end
        end
        check("conv_eoc_seen", 16'(got), 16'd1);
        tick();
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(2);
        check("rst_vfc", 16'(vfc_o), 16'h000);
        check("rst_vout", 16'(vout_o), 16'h000);
        check("rst_en1", 16'(adc1_enable_o), 16'd0);
        check("rst_en2", 16'(adc2_enable_o), 16'd0);
        check("rst_eoc", 16'(eoc_o), 16'd0);
        check("rst_busy", 16'(busy_o), 16'd0);
        check("rst_timeout", 16'(timeout_o), 16'd0);
        check("rst_overrun", 16'(overrun_o), 16'd0);
        check("rst_cnt", sample_cnt_o, 16'd0);
        rst_i = 1'b0;
        tick();

        // ---------------- normal conversion ----------------
        start_i = 1'b1;
        tick();                          // E0
        start_i = 1'b0;
        check("n_en1_high", 16'(adc1_enable_o), 16'd1);
        check("n_en2_high", 16'(adc2_enable_o), 16'd1);
        check("n_busy", 16'(busy_o), 16'd1);
        tick(2);
        adc1_ready_i = 1'b0;             // sampled at E3
        adc2_ready_i = 1'b0;
        tick(37);
        adc1_data_i = 16'h3000;          // captured at E40
        adc1_ready_i = 1'b1;
        tick();
        check("n_vfc", 16'(vfc_o), 16'h600);
        check("n_en1_drop", 16'(adc1_enable_o), 16'd0);
        check("n_en2_still", 16'(adc2_enable_o), 16'd1);
        check("n_no_eoc_early", 16'(eoc_o), 16'd0);
        tick(14);
        adc2_data_i = 16'h1008;          // captured at E55
        adc2_ready_i = 1'b1;
        tick();
        check("n_vout", 16'(vout_o), 16'h201);
        check("n_en2_drop", 16'(adc2_enable_o), 16'd0);
        tick();
        check("n_eoc", 16'(eoc_o), 16'd1);
        check("n_cnt", sample_cnt_o, 16'd1);
        tick();
        check("n_eoc_low", 16'(eoc_o), 16'd0);
        check("n_idle", 16'(busy_o), 16'd0);
        check("n_eoc_count", 16'(eoc_seen), 16'd1);

        // ---------------- negative clamp, simultaneous capture ----------------
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        adc1_ready_i = 1'b0;
        adc2_ready_i = 1'b0;
        tick(4);
        adc1_data_i = 16'h8123;
        adc2_data_i = 16'h7FFF;
        adc1_ready_i = 1'b1;
        adc2_ready_i = 1'b1;
        tick();
        check("s_vfc_neg", 16'(vfc_o), 16'h000);
        check("s_vout_max", 16'(vout_o), 16'hFFF);
        check("s_eoc_not_yet", 16'(eoc_o), 16'd0);
        tick();
        check("s_eoc", 16'(eoc_o), 16'd1);
        tick();
        check("s_eoc_count", 16'(eoc_seen), 16'd2);
        check("s_cnt", sample_cnt_o, 16'd2);

        // ---------------- ack timeout ----------------
        start_i = 1'b1;
        tick();                          // E0: WAIT_ACK, timer 0
        start_i = 1'b0;
        tick(254);                       // E254: still waiting
        check("a_busy_before", 16'(busy_o), 16'd1);
        check("a_en1_before", 16'(adc1_enable_o), 16'd1);
        check("a_to_before", 16'(timeout_o), 16'd0);
        tick();                          // E255: ABORT
        check("a_timeout", 16'(timeout_o), 16'd1);
        check("a_en1_low", 16'(adc1_enable_o), 16'd0);
        check("a_en2_low", 16'(adc2_enable_o), 16'd0);
        tick();
        check("a_idle", 16'(busy_o), 16'd0);
        check("a_vfc_kept", 16'(vfc_o), 16'h000);
        check("a_vout_kept", 16'(vout_o), 16'hFFF);
        check("a_cnt_kept", sample_cnt_o, 16'd2);
        check("a_no_eoc", 16'(eoc_seen), 16'd2);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("a_clr", 16'(timeout_o), 16'd0);

        // ---------------- conversion timeout ----------------
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        adc1_ready_i = 1'b0;
        adc2_ready_i = 1'b0;
        tick();                          // E1: WAIT_DATA, timer 0
        tick(9);
        adc1_data_i = 16'h4008;          // captured at E11
        adc1_ready_i = 1'b1;
        tick();
        check("c_vfc", 16'(vfc_o), 16'h801);
        tick(289);                       // E300: timer 299, still waiting
        check("c_busy_before", 16'(busy_o), 16'd1);
        check("c_en2_before", 16'(adc2_enable_o), 16'd1);
        check("c_to_before", 16'(timeout_o), 16'd0);
        tick();                          // E301: ABORT
        check("c_timeout", 16'(timeout_o), 16'd1);
        check("c_en1_low", 16'(adc1_enable_o), 16'd0);
        check("c_en2_low", 16'(adc2_enable_o), 16'd0);
        tick();
        check("c_idle", 16'(busy_o), 16'd0);
        check("c_vfc_kept", 16'(vfc_o), 16'h801);
        check("c_vout_kept", 16'(vout_o), 16'hFFF);
        check("c_cnt_kept", sample_cnt_o, 16'd2);
        check("c_no_eoc", 16'(eoc_seen), 16'd2);
        adc2_ready_i = 1'b1;

        // ---------------- overrun ----------------
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("o_to_cleared", 16'(timeout_o), 16'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        adc1_ready_i = 1'b0;
        adc2_ready_i = 1'b0;
        tick();                          // WAIT_DATA
        check("o_ovr_before", 16'(overrun_o), 16'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("o_ovr_set", 16'(overrun_o), 16'd1);
        adc1_data_i = 16'h0010;
        adc2_data_i = 16'h0020;
        adc1_ready_i = 1'b1;
        adc2_ready_i = 1'b1;
        tick(2);
        check("o_eoc", 16'(eoc_o), 16'd1);
        tick();
        check("o_idle", 16'(busy_o), 16'd0);
        check("o_one_eoc", 16'(eoc_seen), 16'd3);
        check("o_ovr_sticky", 16'(overrun_o), 16'd1);
        check("o_cnt", sample_cnt_o, 16'd3);
        check("o_vfc", 16'(vfc_o), 16'h002);
        check("o_vout", 16'(vout_o), 16'h004);
        err_clr_i = 1'b1;
        start_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        start_i = 1'b0;
        check("o_ovr_clr", 16'(overrun_o), 16'd0);
        check("o_restart_busy", 16'(busy_o), 16'd1);
        check("o_restart_en1", 16'(adc1_enable_o), 16'd1);
        adc1_ready_i = 1'b0;
        adc2_ready_i = 1'b0;
        tick();
        adc1_data_i = 16'h1000;
        adc2_data_i = 16'hFFF8;
        adc1_ready_i = 1'b1;
        adc2_ready_i = 1'b1;
        tick(2);
        check("o2_eoc", 16'(eoc_o), 16'd1);
        tick();
        check("o2_cnt", sample_cnt_o, 16'd4);
        check("o2_vfc", 16'(vfc_o), 16'h200);
        check("o2_vout_neg", 16'(vout_o), 16'h000);

        // ---------------- reset mid WAIT_DATA ----------------
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        adc1_ready_i = 1'b0;
        adc2_ready_i = 1'b0;
        tick(3);
        check("r_en1_before", 16'(adc1_enable_o), 16'd1);
        rst_i = 1'b1;
        tick();
        check("r_en1", 16'(adc1_enable_o), 16'd0);
        check("r_en2", 16'(adc2_enable_o), 16'd0);
        check("r_busy", 16'(busy_o), 16'd0);
        check("r_vfc", 16'(vfc_o), 16'h000);
        check("r_vout", 16'(vout_o), 16'h000);
        check("r_cnt", sample_cnt_o, 16'd0);
        check("r_eoc", 16'(eoc_o), 16'd0);
        rst_i = 1'b0;
        adc1_ready_i = 1'b1;
        adc2_ready_i = 1'b1;
        tick(3);
        check("r_no_eoc", 16'(eoc_seen), 16'd4);

        // ---------------- counter saturation ----------------
        force dut.sample_cnt_q = 16'hFFFE;
        tick();
        release dut.sample_cnt_q;
        tick();
        check("sat_preset", sample_cnt_o, 16'hFFFE);
        run_conv(16'h0008, 16'h0018);
        check("sat_first", sample_cnt_o, 16'hFFFF);
        check("sat_vout", 16'(vout_o), 16'h003);
        run_conv(16'h0010, 16'h0010);
        check("sat_held", sample_cnt_o, 16'hFFFF);
        check("sat_eoc_count", 16'(eoc_seen), 16'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
